// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Packs decoded RV32I field bundles into 32-bit instruction words and
//            streams them to instruction memory at sequential word addresses.
//            Optional macro: IMM_RANGE_CHECK_EN (flags unrepresentable immediates).
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [8:0]        count,
    output logic              err_opcode,
    output logic              err_ovf,
    output logic              err_imm
);

    localparam logic [6:0]  c_op_r      = 7'b0110011;
    localparam logic [6:0]  c_op_imm    = 7'b0010011;
    localparam logic [6:0]  c_op_load   = 7'b0000011;
    localparam logic [6:0]  c_op_jalr   = 7'b1100111;
    localparam logic [6:0]  c_op_store  = 7'b0100011;
    localparam logic [6:0]  c_op_branch = 7'b1100011;
    localparam logic [6:0]  c_op_lui    = 7'b0110111;
    localparam logic [6:0]  c_op_jal    = 7'b1101111;
    localparam logic [31:0] c_nop       = 32'h0000_0013;
    localparam logic [8:0]  c_max_words = 9'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_ptr;
    logic [8:0]        r_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_err_opcode;
    logic              r_err_ovf;
    logic              r_err_imm;

    logic              w_accept;
    logic              w_is_shift;
    logic [31:0]       w_word;
    logic              w_op_bad;
    logic              w_imm_bad;
    logic [8:0]        w_count_inc;
    logic              w_hit_max;
    logic [ADDR_W-1:0] w_addr;

    assign in_ready    = r_busy && (r_count < c_max_words);
    assign w_accept    = in_valid && in_ready;
    assign w_is_shift  = (in_funct3[1:0] == 2'b01);
    assign w_count_inc = r_count + 9'd1;
    assign w_hit_max   = (w_count_inc == c_max_words);
    assign w_addr      = r_ptr + ADDR_W'({r_count, 2'b00});

    always_comb begin
        w_word   = c_nop;
        w_op_bad = 1'b0;
        case (in_opcode)
            c_op_r:
                w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            c_op_imm:
                if (w_is_shift)
                    w_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                else
                    w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            c_op_load, c_op_jalr:
                w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            c_op_store:
                w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            c_op_branch:
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
            c_op_lui:
                w_word = {in_imm[31:12], in_rd, in_opcode};
            c_op_jal:
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default:
                w_op_bad = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic w_sx12_ok;
    logic w_sx13_ok;
    logic w_sx21_ok;

    // An immediate fits N signed bits when everything above bit N-1 copies the sign
    assign w_sx12_ok = (in_imm[31:11] == {21{in_imm[11]}});
    assign w_sx13_ok = (in_imm[31:12] == {20{in_imm[12]}});
    assign w_sx21_ok = (in_imm[31:20] == {12{in_imm[20]}});

    always_comb begin
        w_imm_bad = 1'b0;
        case (in_opcode)
            c_op_imm:
                w_imm_bad = w_is_shift ? (in_imm[31:5] != 27'd0) : !w_sx12_ok;
            c_op_load, c_op_jalr, c_op_store:
                w_imm_bad = !w_sx12_ok;
            c_op_branch:
                w_imm_bad = in_imm[0] || !w_sx13_ok;
            c_op_jal:
                w_imm_bad = in_imm[0] || !w_sx21_ok;
            c_op_lui:
                w_imm_bad = (in_imm[11:0] != 12'd0);
            default:
                w_imm_bad = 1'b0;
        endcase
    end
`else
    assign w_imm_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ptr        <= '0;
            r_count      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_err_opcode <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_imm    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_ptr        <= base_addr & ~ADDR_W'(3);
                        r_count      <= '0;
                        r_err_opcode <= 1'b0;
                        r_err_ovf    <= 1'b0;
                        r_err_imm    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_word;
                        r_count     <= w_count_inc;
                        if (w_op_bad)
                            r_err_opcode <= 1'b1;
                        if (w_imm_bad)
                            r_err_imm <= 1'b1;
                        if (!in_last && w_hit_max)
                            r_err_ovf <= 1'b1;
                        if (in_last || w_hit_max) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign count      = r_count;
    assign err_opcode = r_err_opcode;
    assign err_ovf    = r_err_ovf;
    assign err_imm    = r_err_imm;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Brief    : Self-checking bench: directed literal cases plus randomized sessions
//            compared every cycle against a field-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    localparam int ADDR_W = 10;
    localparam int MAXW   = 256;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [8:0]        count;
    logic              err_opcode;
    logic              err_ovf;
    logic              err_imm;

    int total = 0;
    int bad   = 0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .count(count),
        .err_opcode(err_opcode), .err_ovf(err_ovf), .err_imm(err_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_word(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
        logic [31:0] base_i;
        base_i = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        case (op)
            7'h33: return (32'(f7) << 25) | (32'(rs2) << 20) | base_i;
            7'h13: if (f3 == 3'd1 || f3 == 3'd5)
                       return (32'(f7) << 25) | ((imm & 32'd31) << 20) | base_i;
                   else
                       return ((imm & 32'hFFF) << 20) | base_i;
            7'h03, 7'h67: return ((imm & 32'hFFF) << 20) | base_i;
            7'h23: return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                          | (32'(f3) << 12) | ((imm & 32'd31) << 7) | 32'(op);
            7'h63: return (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25)
                          | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                          | (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'(op);
            7'h37: return (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
            7'h6F: return (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21)
                          | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12)
                          | (32'(rd) << 7) | 32'(op);
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic logic ref_bad_op(input logic [6:0] op);
        return !(op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F});
    endfunction

    function automatic logic ref_bad_imm(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
        int s;
        s = $signed(imm);
        case (op)
            7'h13: if (f3 == 3'd1 || f3 == 3'd5) return imm > 32'd31;
                   else return (s < -2048) || (s > 2047);
            7'h03, 7'h67, 7'h23: return (s < -2048) || (s > 2047);
            7'h63: return imm[0] || (s < -4096) || (s > 4095);
            7'h6F: return imm[0] || (s < -(1 << 20)) || (s > (1 << 20) - 1);
            7'h37: return (imm & 32'hFFF) != 32'd0;
            default: return 1'b0;
        endcase
`else
        return (f3 === 3'bxxx) && (op === 7'bx) && (imm === 32'bx);
`endif
    endfunction

    logic        m_on = 1'b0;
    logic        m_run, m_fin, m_we, m_eop, m_eovf, m_eimm;
    int          m_ptr, m_count;
    logic [31:0] m_addr, m_data;

    always @(posedge clk) begin
        if (reset) begin
            m_on <= 1'b1; m_run <= 1'b0; m_fin <= 1'b0; m_we <= 1'b0;
            m_ptr <= 0; m_count <= 0; m_addr <= 0; m_data <= 0;
            m_eop <= 1'b0; m_eovf <= 1'b0; m_eimm <= 1'b0;
        end else if (m_on) begin
            m_we <= 1'b0;
            if (!m_run && start) begin
                m_run <= 1'b1; m_fin <= 1'b0;
                m_ptr <= int'(base_addr) / 4 * 4;
                m_count <= 0; m_eop <= 1'b0; m_eovf <= 1'b0; m_eimm <= 1'b0;
            end else if (m_run && in_valid && m_count < MAXW) begin
                m_we   <= 1'b1;
                m_addr <= 32'((m_ptr + 4 * m_count) % (1 << ADDR_W));
                m_data <= ref_word(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
                m_count <= m_count + 1;
                if (ref_bad_op(in_opcode)) m_eop <= 1'b1;
                if (ref_bad_imm(in_opcode, in_funct3, in_imm)) m_eimm <= 1'b1;
                if (in_last || m_count + 1 == MAXW) begin
                    m_run <= 1'b0; m_fin <= 1'b1;
                end
                if (!in_last && m_count + 1 == MAXW) m_eovf <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) begin
                chk("mem_addr", 32'(mem_addr), m_addr);
                chk("mem_wdata", mem_wdata, m_data);
            end
            chk("in_ready", 32'(in_ready), 32'(m_run && m_count < MAXW));
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_fin));
            chk("count", 32'(count), 32'(m_count));
            chk("err_opcode", 32'(err_opcode), 32'(m_eop));
            chk("err_ovf", 32'(err_ovf), 32'(m_eovf));
            chk("err_imm", 32'(err_imm), 32'(m_eimm));
        end
    end

    // Captures DUT writes so directed cases can inspect memory contents
    logic [31:0] mem [0:255];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        start = 1'b1; base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        logic rdy, acc;
        in_opcode = op; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin acc = 1'b1; break; end
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready never high, op=0x%02h", op);
        end
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return r;
            1: return {{20{r[11]}}, r[11:0]};
            2: return {{19{r[12]}}, r[12:1], 1'b0};
            3: return {{11{r[20]}}, r[20:1], 1'b0};
            4: return {r[31:12], 12'd0};
            default: return 32'(r[4:0]);
        endcase
    endfunction

    logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F};

    task automatic rand_bundle(input logic last);
        logic [6:0] op;
        op = ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 7)] : 7'($urandom);
        send(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             rand_imm(), last);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0;
        in_rs2 = '0; in_imm = '0;
        repeat (3) tick();
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // addi x1,x0,5 ; add x3,x1,x2
        do_start(10'h040);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        idle(1);
        chk("addi_word", mem[10'h040 >> 2], 32'h0050_0093);
        chk("add_word", mem[10'h044 >> 2], 32'h0020_81B3);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_count", 32'(count), 32'd2);

        // sub, sw, beq, lui, jal
        do_start(10'h080);
        send(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd16, 1'b0);
        send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        idle(1);
        chk("sub_word", mem[8'h20], 32'h4020_81B3);
        chk("sw_word", mem[8'h21], 32'h0020_A423);
        chk("beq_word", mem[8'h22], 32'h0020_8863);
        chk("lui_word", mem[8'h23], 32'h1234_52B7);
        chk("jal_word", mem[8'h24], 32'h0080_00EF);

        // unsupported opcode
        do_start(10'h100);
        send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
        idle(1);
        chk("bad_op_word", mem[8'h40], 32'h0000_0013);
        chk("bad_op_flag", 32'(err_opcode), 32'd1);

        // address wrap; base low bits ignored
        do_start(10'h3FE);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        idle(1);
        chk("wrap_first", mem[8'hFF], 32'h0050_0093);
        chk("wrap_second", mem[8'h00], 32'h0020_81B3);

        // addi imm=0x800
        do_start(10'h0C0);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b1);
        idle(1);
        chk("imm_word", mem[8'h30], 32'h8000_0093);
`ifdef IMM_RANGE_CHECK_EN
        chk("imm_flag", 32'(err_imm), 32'd1);
`else
        chk("imm_flag", 32'(err_imm), 32'd0);
`endif

        // overflow: MAX_WORDS bundles, never in_last
        do_start(10'h200);
        for (int i = 0; i < MAXW; i++)
            send(7'h13, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'(i % 2048), 1'b0);
        chk("ovf_flag", 32'(err_ovf), 32'd1);
        chk("ovf_done", 32'(done), 32'd1);
        chk("ovf_count", 32'(count), 32'd256);
        chk("ovf_ready", 32'(in_ready), 32'd0);
        idle(1);

        // reset while a bundle is being accepted
        do_start(10'h010);
        send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        in_valid = 1'b1; in_last = 1'b0; reset = 1'b1;
        tick();
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        tick();

        // randomized sessions, with ignored starts in RUN and restarts straight from DONE
        for (int s = 0; s < 60; s++) begin
            int n;
            do_start(10'($urandom));
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    start = ($urandom_range(0, 3) == 0);
                    base_addr = 10'($urandom);
                    tick();
                    start = 1'b0;
                end
                rand_bundle(k == n - 1);
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
